ste_snd_dma: RTL and testbench

STE DMA sound fetch engine: holds the frame start/end and address-counter registers at $FF8900–$FF8913 and issues word reads to RAM whenever the shifter's audio FIFO asks for data (SREQ). It sits directly upstream of the shifter's DMA-sound FIFO. It drives the memory-slot request toward the MCU arbiter and the SLOAD_N strobe that writes MDIN into the FIFO. It signals end-of-frame to the MFP.

---
 rtl/ste_snd_pkg.sv | 45 ++++
 rtl/ste_snd_dma_if.sv | 31 +++
 rtl/snd_addr_regs.sv | 49 ++++
 rtl/ste_snd_dma.sv | 186 ++++++++++++++++++
 tb/tb_ste_snd_dma.sv | 286 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/ste_snd_pkg.sv
// ste_snd_pkg
// Shared constants for the STE DMA sound fetch engine: register word
// indices of the $FF89xx sound window, control bit positions, byte-lane
// selects for the 24-bit address registers and the FSM state encoding.
package ste_snd_pkg;

    // Register word indices (A[6:1])
    localparam logic [5:0] SND_CTRL    = 6'h00;
    localparam logic [5:0] SND_START_H = 6'h01;
    localparam logic [5:0] SND_START_M = 6'h02;
    localparam logic [5:0] SND_START_L = 6'h03;
    localparam logic [5:0] SND_CNT_H   = 6'h04;
    localparam logic [5:0] SND_CNT_M   = 6'h05;
    localparam logic [5:0] SND_CNT_L   = 6'h06;
    localparam logic [5:0] SND_END_H   = 6'h07;
    localparam logic [5:0] SND_END_M   = 6'h08;
    localparam logic [5:0] SND_END_L   = 6'h09;

    // Control register bit positions
    localparam int CTRL_PLAY = 0;
    localparam int CTRL_LOOP = 1;

    // Byte lanes of a 24-bit address register
    localparam logic [1:0] SEL_HI  = 2'd0;
    localparam logic [1:0] SEL_MID = 2'd1;
    localparam logic [1:0] SEL_LO  = 2'd2;

    // Fetch FSM states
    localparam logic [2:0] S_IDLE      = 3'd0;
    localparam logic [2:0] S_CHECK     = 3'd1;
    localparam logic [2:0] S_REQ       = 3'd2;
    localparam logic [2:0] S_LOAD      = 3'd3;
    localparam logic [2:0] S_HOLD      = 3'd4;
    localparam logic [2:0] S_FRAME_END = 3'd5;

    // Extract one byte lane of a 24-bit address for register reads
    function automatic logic [7:0] pickByte(input logic [23:0] value, input logic [1:0] sel);
        case (sel)
            SEL_HI:  pickByte = value[23:16];
            SEL_MID: pickByte = value[15:8];
            default: pickByte = value[7:0];
        endcase
    endfunction

endpackage

// File: rtl/ste_snd_dma_if.sv
// ste_snd_dma_if
// Bundles the CPU register port, the memory-slot handshake toward the MCU
// arbiter, the FIFO load strobe and the MFP status lines.
//   slave  : the DMA sound engine side
//   master : the system side (CPU, arbiter, shifter FIFO, MFP)
interface ste_snd_dma_if #(
    parameter int ADDR_W = 23
);
    logic              CS;
    logic              RW;
    logic [5:0]        A;
    logic [7:0]        DIN;
    logic [15:0]       DOUT;
    logic              SREQ;
    logic              MREQ;
    logic [ADDR_W-1:0] ADDR;
    logic              SGNT;
    logic              SLOAD_N;
    logic              XSINT;
    logic              SACTIVE;

    modport slave (
        input  CS, RW, A, DIN, SREQ, SGNT,
        output DOUT, MREQ, ADDR, SLOAD_N, XSINT, SACTIVE
    );

    modport master (
        output CS, RW, A, DIN, SREQ, SGNT,
        input  DOUT, MREQ, ADDR, SLOAD_N, XSINT, SACTIVE
    );
endinterface

// File: rtl/snd_addr_regs.sv
// snd_addr_regs
// 24-bit address register written one byte lane at a time, with bit 0
// forced to zero (word aligned), plus a shadow copy captured at frame start
// so CPU writes during a frame only affect the next frame.
//   clk, rst  : clock, async active-high reset
//   i_we      : write strobe for the lane selected by i_sel
//   i_sel     : byte lane (hi/mid/lo)
//   i_din     : write data
//   i_load    : copy the live value into the shadow
//   o_value   : live value (CPU visible)
//   o_shadow  : value used by the running frame
module snd_addr_regs
    import ste_snd_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        i_we,
    input  logic [1:0]  i_sel,
    input  logic [7:0]  i_din,
    input  logic        i_load,
    output logic [23:0] o_value,
    output logic [23:0] o_shadow
);

    logic [23:0] r_value;
    logic [23:0] r_shadow;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_value  <= '0;
            r_shadow <= '0;
        end else begin
            if (i_we) begin
                case (i_sel)
                    SEL_HI:  r_value[23:16] <= i_din;
                    SEL_MID: r_value[15:8]  <= i_din;
                    default: r_value[7:0]   <= {i_din[7:1], 1'b0};
                endcase
            end
            if (i_load) begin
                r_shadow <= r_value;
            end
        end
    end

    assign o_value  = r_value;
    assign o_shadow = r_shadow;

endmodule

// File: rtl/ste_snd_dma.sv
// ste_snd_dma
// STE DMA sound fetch engine. Holds the control, start, end and counter
// registers of the $FF89xx window and fetches one word per memory slot
// whenever the shifter FIFO has room.
//   clk32   : system clock
//   reset   : async active-high reset
//   bus     : register port, MREQ/ADDR/SGNT slot handshake, SLOAD_N FIFO
//             strobe, XSINT end-of-frame pulse, SACTIVE playing level
module ste_snd_dma
    import ste_snd_pkg::*;
#(
    parameter int ADDR_W  = 23,
    parameter int HOLDOFF = 2
) (
    input  logic         clk32,
    input  logic         reset,
    ste_snd_dma_if.slave bus
);

    localparam int HOLD_W = (HOLDOFF > 1) ? $clog2(HOLDOFF) : 1;
    localparam logic [HOLD_W-1:0] HOLD_INIT = HOLD_W'((HOLDOFF > 0) ? HOLDOFF - 1 : 0);

    logic [2:0]        r_state;
    logic              r_play;
    logic              r_loop;
    logic [23:0]       r_counter;
    logic [HOLD_W-1:0] r_hold;

    logic [2:0]  w_next;
    logic        w_wrCtrl;
    logic        w_wrStart;
    logic        w_wrEnd;
    logic [1:0]  w_sel;
    logic [7:0]  w_rdByte;
    logic [23:0] w_start;
    logic [23:0] w_startSh;
    logic [23:0] w_end;
    logic [23:0] w_endSh;
    logic        w_mreq;
    logic        w_restart;
    logic        w_frameLoad;
    logic        w_clearPlay;

    // Write decode: counter indices are read-only and simply ignored
    always_comb begin
        w_wrCtrl  = 1'b0;
        w_wrStart = 1'b0;
        w_wrEnd   = 1'b0;
        w_sel     = SEL_HI;
        if (bus.CS && !bus.RW) begin
            case (bus.A)
                SND_CTRL:    w_wrCtrl = 1'b1;
                SND_START_H: begin w_wrStart = 1'b1; w_sel = SEL_HI;  end
                SND_START_M: begin w_wrStart = 1'b1; w_sel = SEL_MID; end
                SND_START_L: begin w_wrStart = 1'b1; w_sel = SEL_LO;  end
                SND_END_H:   begin w_wrEnd   = 1'b1; w_sel = SEL_HI;  end
                SND_END_M:   begin w_wrEnd   = 1'b1; w_sel = SEL_MID; end
                SND_END_L:   begin w_wrEnd   = 1'b1; w_sel = SEL_LO;  end
                default:     ;
            endcase
        end
    end

    snd_addr_regs u_start (
        .clk      (clk32),
        .rst      (reset),
        .i_we     (w_wrStart),
        .i_sel    (w_sel),
        .i_din    (bus.DIN),
        .i_load   (w_frameLoad),
        .o_value  (w_start),
        .o_shadow (w_startSh)
    );

    snd_addr_regs u_end (
        .clk      (clk32),
        .rst      (reset),
        .i_we     (w_wrEnd),
        .i_sel    (w_sel),
        .i_din    (bus.DIN),
        .i_load   (w_frameLoad),
        .o_value  (w_end),
        .o_shadow (w_endSh)
    );

    // A frame (re)starts either when play is seen set while idle (idle is
    // only ever entered with play cleared, so this is the 0->1 edge) or on a
    // loop restart of a non-empty frame; both reload shadows and counter.
    assign w_restart   = (r_state == S_FRAME_END) && r_play && r_loop && (w_startSh < w_endSh);
    assign w_frameLoad = ((r_state == S_IDLE) && r_play) || w_restart;
    assign w_clearPlay = (r_state == S_FRAME_END) && !w_restart;

    // Requests are only raised while the FIFO has room and play is still set,
    // so an abort write drops MREQ in the very next cycle.
    assign w_mreq = (r_state == S_REQ) && bus.SREQ && r_play;

    // Next-state logic; clearing play aborts at each state boundary
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (r_play) w_next = S_CHECK;
            end
            S_CHECK: begin
                if (!r_play)                   w_next = S_IDLE;
                else if (r_counter >= w_endSh) w_next = S_FRAME_END;
                else                           w_next = S_REQ;
            end
            S_REQ: begin
                if (!r_play)                  w_next = S_IDLE;
                else if (w_mreq && bus.SGNT)  w_next = S_LOAD;
            end
            S_LOAD: begin
                if (!r_play)          w_next = S_IDLE;
                else if (HOLDOFF == 0) w_next = S_CHECK;
                else                  w_next = S_HOLD;
            end
            S_HOLD: begin
                if (!r_play)          w_next = S_IDLE;
                else if (r_hold == '0) w_next = S_CHECK;
            end
            S_FRAME_END: begin
                w_next = w_restart ? S_CHECK : S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    // State, control, counter and holdoff registers. A CPU control write
    // wins over the end-of-frame play clear in the same cycle.
    always_ff @(posedge clk32 or posedge reset) begin
        if (reset) begin
            r_state   <= S_IDLE;
            r_play    <= 1'b0;
            r_loop    <= 1'b0;
            r_counter <= '0;
            r_hold    <= '0;
        end else begin
            r_state <= w_next;
            if (w_wrCtrl) begin
                r_play <= bus.DIN[CTRL_PLAY];
                r_loop <= bus.DIN[CTRL_LOOP];
            end else if (w_clearPlay) begin
                r_play <= 1'b0;
            end
            if (w_frameLoad) begin
                r_counter <= w_start;
            end else if (r_state == S_LOAD) begin
                r_counter <= r_counter + 24'd2;
            end
            if (r_state == S_LOAD) begin
                r_hold <= HOLD_INIT;
            end else if ((r_state == S_HOLD) && (r_hold != '0)) begin
                r_hold <= r_hold - HOLD_W'(1);
            end
        end
    end

    // Combinational register read mux
    always_comb begin
        w_rdByte = 8'h00;
        if (bus.CS && bus.RW) begin
            case (bus.A)
                SND_CTRL:    w_rdByte = {6'b0, r_loop, r_play};
                SND_START_H: w_rdByte = pickByte(w_start, SEL_HI);
                SND_START_M: w_rdByte = pickByte(w_start, SEL_MID);
                SND_START_L: w_rdByte = pickByte(w_start, SEL_LO);
                SND_CNT_H:   w_rdByte = pickByte(r_counter, SEL_HI);
                SND_CNT_M:   w_rdByte = pickByte(r_counter, SEL_MID);
                SND_CNT_L:   w_rdByte = pickByte(r_counter, SEL_LO);
                SND_END_H:   w_rdByte = pickByte(w_end, SEL_HI);
                SND_END_M:   w_rdByte = pickByte(w_end, SEL_MID);
                SND_END_L:   w_rdByte = pickByte(w_end, SEL_LO);
                default:     w_rdByte = 8'h00;
            endcase
        end
    end

    assign bus.DOUT    = {8'h00, w_rdByte};
    assign bus.MREQ    = w_mreq;
    assign bus.ADDR    = w_mreq ? r_counter[ADDR_W:1] : '0;
    assign bus.SLOAD_N = (r_state != S_LOAD);
    assign bus.XSINT   = (r_state == S_FRAME_END);
    assign bus.SACTIVE = r_play;

endmodule

// File: tb/tb_ste_snd_dma.sv
// tb_ste_snd_dma
// Directed bench for ste_snd_dma. Expected fetch word addresses are queued
// when a frame is started and checked against ADDR whenever the bench's
// arbiter model grants a slot.
module tb_ste_snd_dma;
    import ste_snd_pkg::*;

    localparam int HOLDOFF = 2;

    logic clk32 = 1'b0;
    logic reset;

    ste_snd_dma_if #(.ADDR_W(23)) bus ();

    ste_snd_dma #(.ADDR_W(23), .HOLDOFF(HOLDOFF)) dut (
        .clk32 (clk32),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk32 = ~clk32;

    int total = 0;
    int bad   = 0;

    logic [31:0] expQ[$];
    logic        gntEn = 1'b0;
    logic        prevGrant = 1'b0;
    int          cyc = 0;
    int          loadCount = 0;
    int          xsCount = 0;
    int          lastLoadCyc = 0;
    int          xsCyc = 0;

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Arbiter model and output monitor: grants one cycle after MREQ is seen,
    // checks the granted address and the load strobe that must follow.
    always @(negedge clk32) begin
        cyc++;
        if (bus.SLOAD_N === 1'b0) begin
            loadCount++;
            lastLoadCyc = cyc;
        end
        if (bus.XSINT === 1'b1) begin
            xsCount++;
            xsCyc = cyc;
        end
        if (prevGrant) checkOutput("sload_after_grant", {31'b0, bus.SLOAD_N}, 32'd0);
        prevGrant = 1'b0;
        if (reset === 1'b1 || bus.SGNT === 1'b1) begin
            bus.SGNT = 1'b0;
        end else if (gntEn && bus.MREQ === 1'b1) begin
            checkOutput("fetch_addr", {9'b0, bus.ADDR},
                        (expQ.size() > 0) ? expQ.pop_front() : 32'hDEAD_BEEF);
            bus.SGNT  = 1'b1;
            prevGrant = 1'b1;
        end
    end

    task automatic applyStimulus(input logic [5:0] a, input logic [7:0] d);
        @(negedge clk32);
        bus.CS = 1'b1; bus.RW = 1'b0; bus.A = a; bus.DIN = d;
        @(negedge clk32);
        bus.CS = 1'b0; bus.RW = 1'b1;
    endtask

    task automatic checkReg(input string tag, input logic [5:0] a, input logic [7:0] e);
        @(negedge clk32);
        bus.CS = 1'b1; bus.RW = 1'b1; bus.A = a;
        #1;
        checkOutput(tag, {16'b0, bus.DOUT}, {24'b0, e});
        bus.CS = 1'b0;
    endtask

    task automatic setRange(input logic [23:0] s, input logic [23:0] e);
        applyStimulus(SND_START_H, s[23:16]);
        applyStimulus(SND_START_M, s[15:8]);
        applyStimulus(SND_START_L, s[7:0]);
        applyStimulus(SND_END_H, e[23:16]);
        applyStimulus(SND_END_M, e[15:8]);
        applyStimulus(SND_END_L, e[7:0]);
    endtask

    task automatic waitIdle(input int maxCyc);
        int n = 0;
        while (bus.SACTIVE === 1'b1 && n < maxCyc) begin
            @(negedge clk32); #2; n++;
        end
        checkOutput("wait_idle", {31'b0, bus.SACTIVE}, 32'd0);
    endtask

    task automatic waitLoads(input int target, input int maxCyc);
        int n = 0;
        while (loadCount < target && n < maxCyc) begin
            @(negedge clk32); #2; n++;
        end
        checkOutput("wait_loads", loadCount, target);
    endtask

    task automatic waitXs(input int target, input int maxCyc);
        int n = 0;
        while (xsCount < target && n < maxCyc) begin
            @(negedge clk32); #2; n++;
        end
        checkOutput("wait_xsint", xsCount, target);
    endtask

    task automatic waitSignal(input string tag, input int which, input int maxCyc);
        int n = 0;
        logic v;
        v = (which == 0) ? bus.MREQ : ~bus.SLOAD_N;
        while (v !== 1'b1 && n < maxCyc) begin
            @(negedge clk32); #2; n++;
            v = (which == 0) ? bus.MREQ : ~bus.SLOAD_N;
        end
        checkOutput(tag, {31'b0, v}, 32'd1);
    endtask

    int baseL;
    int baseX;

    initial begin
        reset = 1'b1;
        bus.CS = 1'b0; bus.RW = 1'b1; bus.A = '0; bus.DIN = '0; bus.SREQ = 1'b1;
        repeat (3) @(negedge clk32);
        #1;
        checkOutput("rst_dout",    {16'b0, bus.DOUT},   32'd0);
        checkOutput("rst_mreq",    {31'b0, bus.MREQ},   32'd0);
        checkOutput("rst_addr",    {9'b0, bus.ADDR},    32'd0);
        checkOutput("rst_sload_n", {31'b0, bus.SLOAD_N}, 32'd1);
        checkOutput("rst_xsint",   {31'b0, bus.XSINT},  32'd0);
        checkOutput("rst_sactive", {31'b0, bus.SACTIVE}, 32'd0);
        reset = 1'b0;
        checkReg("rst_ctrl", SND_CTRL, 8'h00);
        checkReg("rst_cnt_l", SND_CNT_L, 8'h00);
        checkReg("rst_start_h", SND_START_H, 8'h00);
        checkReg("other_index", 6'h0A, 8'h00);

        // Plain 4-word frame
        $display("[TB] single frame");
        gntEn = 1'b1;
        setRange(24'h010000, 24'h010008);
        for (int i = 0; i < 4; i++) expQ.push_back(32'h8000 + i);
        baseL = loadCount; baseX = xsCount;
        applyStimulus(SND_CTRL, 8'h01);
        checkOutput("sactive_after_play", {31'b0, bus.SACTIVE}, 32'd1);
        checkOutput("mreq_idle_cycle", {31'b0, bus.MREQ}, 32'd0);
        @(negedge clk32); #2;
        checkOutput("mreq_check_cycle", {31'b0, bus.MREQ}, 32'd0);
        @(negedge clk32); #2;
        checkOutput("mreq_two_after_write", {31'b0, bus.MREQ}, 32'd1);
        waitIdle(200);
        checkOutput("f1_loads", loadCount - baseL, 32'd4);
        checkOutput("f1_xsint", xsCount - baseX, 32'd1);
        checkOutput("f1_xs_latency", xsCyc - lastLoadCyc, HOLDOFF + 2);
        checkOutput("f1_queue", expQ.size(), 32'd0);
        checkReg("f1_ctrl", SND_CTRL, 8'h00);
        checkReg("f1_cnt_m", SND_CNT_M, 8'h00);
        checkReg("f1_cnt_l", SND_CNT_L, 8'h08);

        // Looping frame, end shortened mid-frame
        $display("[TB] loop frame");
        for (int i = 0; i < 4; i++) expQ.push_back(32'h8000 + i);
        for (int i = 0; i < 2; i++) expQ.push_back(32'h8000 + i);
        baseL = loadCount; baseX = xsCount;
        applyStimulus(SND_CTRL, 8'h03);
        waitLoads(baseL + 2, 100);
        applyStimulus(SND_END_L, 8'h04);
        waitXs(baseX + 1, 100);
        checkReg("loop_cnt_h", SND_CNT_H, 8'h01);
        checkReg("loop_cnt_m", SND_CNT_M, 8'h00);
        checkReg("loop_cnt_l", SND_CNT_L, 8'h00);
        applyStimulus(SND_CTRL, 8'h01);
        waitIdle(200);
        checkOutput("loop_loads", loadCount - baseL, 32'd6);
        checkOutput("loop_xsint", xsCount - baseX, 32'd2);
        checkOutput("loop_queue", expQ.size(), 32'd0);

        // FIFO full stall
        $display("[TB] sreq stall");
        setRange(24'h030000, 24'h030004);
        bus.SREQ = 1'b0;
        expQ.push_back(32'h18000);
        expQ.push_back(32'h18001);
        baseL = loadCount; baseX = xsCount;
        applyStimulus(SND_CTRL, 8'h01);
        repeat (100) @(negedge clk32);
        #2;
        checkOutput("stall_mreq", {31'b0, bus.MREQ}, 32'd0);
        checkOutput("stall_addr", {9'b0, bus.ADDR}, 32'd0);
        checkOutput("stall_loads", loadCount - baseL, 32'd0);
        bus.SREQ = 1'b1;
        waitIdle(200);
        checkOutput("stall_loads_after", loadCount - baseL, 32'd2);
        checkOutput("stall_xsint", xsCount - baseX, 32'd1);
        checkOutput("stall_queue", expQ.size(), 32'd0);

        // Empty frame with loop set
        $display("[TB] empty frame");
        setRange(24'h020000, 24'h020000);
        baseL = loadCount; baseX = xsCount;
        applyStimulus(SND_CTRL, 8'h03);
        waitIdle(50);
        repeat (5) @(negedge clk32);
        checkOutput("empty_loads", loadCount - baseL, 32'd0);
        checkOutput("empty_xsint", xsCount - baseX, 32'd1);
        checkReg("empty_ctrl", SND_CTRL, 8'h02);

        // Abort while requesting
        $display("[TB] abort in REQ");
        gntEn = 1'b0;
        setRange(24'h040000, 24'h040010);
        baseL = loadCount; baseX = xsCount;
        applyStimulus(SND_CTRL, 8'h01);
        waitSignal("abort_mreq_up", 0, 20);
        applyStimulus(SND_CTRL, 8'h00);
        checkOutput("abort_mreq_down", {31'b0, bus.MREQ}, 32'd0);
        repeat (5) @(negedge clk32);
        #2;
        checkOutput("abort_xsint", xsCount - baseX, 32'd0);
        checkOutput("abort_sactive", {31'b0, bus.SACTIVE}, 32'd0);
        checkReg("abort_cnt_h", SND_CNT_H, 8'h04);
        checkReg("abort_cnt_l", SND_CNT_L, 8'h00);

        // Asynchronous reset in LOAD
        $display("[TB] reset in LOAD");
        gntEn = 1'b1;
        setRange(24'h050000, 24'h050010);
        expQ.push_back(32'h28000);
        applyStimulus(SND_CTRL, 8'h01);
        waitSignal("load_seen", 1, 20);
        gntEn = 1'b0;
        reset = 1'b1;
        #1;
        checkOutput("arst_sload_n", {31'b0, bus.SLOAD_N}, 32'd1);
        checkOutput("arst_mreq",    {31'b0, bus.MREQ},   32'd0);
        checkOutput("arst_sactive", {31'b0, bus.SACTIVE}, 32'd0);
        checkOutput("arst_xsint",   {31'b0, bus.XSINT},  32'd0);
        checkOutput("arst_addr",    {9'b0, bus.ADDR},    32'd0);
        @(negedge clk32);
        reset = 1'b0;
        checkReg("arst_ctrl", SND_CTRL, 8'h00);
        checkReg("arst_start_h", SND_START_H, 8'h00);
        checkReg("arst_cnt_h", SND_CNT_H, 8'h00);
        checkReg("arst_end_m", SND_END_M, 8'h00);
        checkOutput("arst_queue", expQ.size(), 32'd0);

        // Start above end near the top of the space: ends immediately
        $display("[TB] top of address space");
        gntEn = 1'b1;
        setRange(24'hFFFFFD, 24'h000002);
        checkReg("mask_start_l", SND_START_L, 8'hFC);
        baseL = loadCount; baseX = xsCount;
        applyStimulus(SND_CTRL, 8'h01);
        waitIdle(50);
        checkOutput("wrap_loads", loadCount - baseL, 32'd0);
        checkOutput("wrap_xsint", xsCount - baseX, 32'd1);
        checkReg("wrap_cnt_l", SND_CNT_L, 8'hFC);

        // Last two words of the space
        setRange(24'hFFFFFA, 24'hFFFFFF);
        checkReg("mask_end_l", SND_END_L, 8'hFE);
        expQ.push_back(32'h7FFFFD);
        expQ.push_back(32'h7FFFFE);
        baseL = loadCount; baseX = xsCount;
        applyStimulus(SND_CTRL, 8'h01);
        waitIdle(100);
        checkOutput("top_loads", loadCount - baseL, 32'd2);
        checkOutput("top_xsint", xsCount - baseX, 32'd1);
        checkOutput("top_queue", expQ.size(), 32'd0);
        applyStimulus(SND_CNT_L, 8'h55);
        checkReg("cnt_readonly", SND_CNT_L, 8'hFE);
        checkReg("top_cnt_h", SND_CNT_H, 8'hFF);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
